// File: rtl/sata_user_data_source.sv
// -----------------------------------------------------------------------------
// sata_user_data_source
//
// Deterministic pattern producer for the write side of the SATA stack's
// ping-pong user input FIFO. On a rising request it streams write_count words,
// starting at pattern_seed and incrementing by one per word (wrapping modulo
// 2^DATA_WIDTH). The stream is split into chunks, one chunk per channel grant,
// each no longer than the capacity reported for the granted channel. Because
// every word is predictable, downstream checkers can verify the stream.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-low reset
//   enable         level request to run one transfer
//   write_count    total words to transfer, sampled at transfer start
//   pattern_seed   value of word 0, sampled at transfer start
//   busy           transfer in progress
//   finished       transfer completed; held until enable drops
//   words_written  words strobed in the current or last transfer
//   ready          ping-pong FIFO channel ready flags
//   activate       channel ownership, one-hot or zero
//   fifo_size      capacity of the channel being granted
//   fifo_data      write data
//   strobe         write-data strobe
// -----------------------------------------------------------------------------
module sata_user_data_source #(
   parameter int SIZE_WIDTH = 24,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [SIZE_WIDTH-1:0] write_count,
   input  logic [DATA_WIDTH-1:0] pattern_seed,
   output logic                  busy,
   output logic                  finished,
   output logic [SIZE_WIDTH-1:0] words_written,
   input  logic [1:0]            ready,
   output logic [1:0]            activate,
   input  logic [SIZE_WIDTH-1:0] fifo_size,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  strobe
);

   localparam logic [SIZE_WIDTH-1:0] SIZE_ZERO = {SIZE_WIDTH{1'b0}};
   localparam logic [SIZE_WIDTH-1:0] SIZE_ONE  = {{(SIZE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRAB    = 3'd1,
      WRITE   = 3'd2,
      RELEASE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t                state_r,     state_s;
   logic [SIZE_WIDTH-1:0] remaining_r, remaining_s;
   logic [SIZE_WIDTH-1:0] chunk_r,     chunk_s;
   logic [SIZE_WIDTH-1:0] words_r,     words_s;
   logic [DATA_WIDTH-1:0] next_data_r, next_data_s;
   logic [DATA_WIDTH-1:0] fifo_data_r, fifo_data_s;
   logic [1:0]            activate_r,  activate_s;
   logic                  busy_r,      busy_s;
   logic                  finished_r,  finished_s;
   logic                  strobe_r,    strobe_s;

   // Smaller of the granted channel capacity and the words still owed.
   function automatic logic [SIZE_WIDTH-1:0] min_size(
      input logic [SIZE_WIDTH-1:0] a,
      input logic [SIZE_WIDTH-1:0] b
   );
      if (a < b) begin
         min_size = a;
      end else begin
         min_size = b;
      end
   endfunction

   // Next-state and next-output decode; all outputs are registered from here.
   always_comb begin
      state_s     = state_r;
      remaining_s = remaining_r;
      chunk_s     = chunk_r;
      words_s     = words_r;
      next_data_s = next_data_r;
      fifo_data_s = fifo_data_r;
      activate_s  = activate_r;
      strobe_s    = 1'b0;

      case (state_r)
         IDLE: begin
            activate_s = 2'b00;
            if (enable && !finished_r) begin
               remaining_s = write_count;
               next_data_s = pattern_seed;
               words_s     = SIZE_ZERO;
               if (write_count == SIZE_ZERO) begin
                  state_s = DONE;
               end else begin
                  state_s = GRAB;
               end
            end else begin
               state_s = IDLE;
            end
         end

         GRAB: begin
            if (activate_r == 2'b00) begin
               // Channel 0 has priority when both channels are ready.
               if (ready[0]) begin
                  activate_s = 2'b01;
               end else if (ready[1]) begin
                  activate_s = 2'b10;
               end else begin
                  activate_s = 2'b00;
               end
            end else begin
               // fifo_size is only meaningful once the grant is visible, so
               // the chunk is taken one cycle after activate rises.
               chunk_s = min_size(fifo_size, remaining_r);
               state_s = WRITE;
            end
         end

         WRITE: begin
            if (chunk_r == SIZE_ZERO) begin
               // Zero-capacity grant: hand the channel back instead of stalling.
               state_s = RELEASE;
            end else begin
               strobe_s    = 1'b1;
               fifo_data_s = next_data_r;
               next_data_s = next_data_r + DATA_ONE;
               words_s     = words_r + SIZE_ONE;
               remaining_s = remaining_r - SIZE_ONE;
               chunk_s     = chunk_r - SIZE_ONE;
               if (chunk_r == SIZE_ONE) begin
                  state_s = RELEASE;
               end else begin
                  state_s = WRITE;
               end
            end
         end

         RELEASE: begin
            activate_s = 2'b00;
            if (remaining_r == SIZE_ZERO) begin
               state_s = DONE;
            end else if (!enable) begin
               state_s = IDLE;
            end else begin
               state_s = GRAB;
            end
         end

         DONE: begin
            activate_s = 2'b00;
            if (!enable) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end

         default: begin
            state_s    = IDLE;
            activate_s = 2'b00;
         end
      endcase

      // Status flags follow the state being entered so they line up with it.
      busy_s     = (state_s == GRAB) || (state_s == WRITE) || (state_s == RELEASE);
      finished_s = (state_s == DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         remaining_r <= SIZE_ZERO;
         chunk_r     <= SIZE_ZERO;
         words_r     <= SIZE_ZERO;
         next_data_r <= DATA_ZERO;
         fifo_data_r <= DATA_ZERO;
         activate_r  <= 2'b00;
         busy_r      <= 1'b0;
         finished_r  <= 1'b0;
         strobe_r    <= 1'b0;
      end else begin
         state_r     <= state_s;
         remaining_r <= remaining_s;
         chunk_r     <= chunk_s;
         words_r     <= words_s;
         next_data_r <= next_data_s;
         fifo_data_r <= fifo_data_s;
         activate_r  <= activate_s;
         busy_r      <= busy_s;
         finished_r  <= finished_s;
         strobe_r    <= strobe_s;
      end
   end

   assign busy          = busy_r;
   assign finished      = finished_r;
   assign words_written = words_r;
   assign activate      = activate_r;
   assign fifo_data     = fifo_data_r;
   assign strobe        = strobe_r;

endmodule

// File: doc/sata_user_data_source.md
Name: sata_user_data_source

Overview:
- Pattern-generating producer that feeds the write side of the SATA stack's ping-pong user input FIFO (user_din / user_din_stb / user_din_ready / user_din_activate / user_din_size).
- Used by the stack-level bench and by bring-up builds to push a deterministic, checkable word stream toward the hard drive.
- Downstream checkers can predict every word.

Parameters:
- SIZE_WIDTH, 24, width of the FIFO size input, the write count input and the word counters.
- DATA_WIDTH, 32, width of the generated data word. Fixed at 32 for the SATA stack.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- enable  in  1  level request to run one transfer
- write_count  in  SIZE_WIDTH  total words to transfer; sampled at transfer start
- pattern_seed  in  DATA_WIDTH  value of word 0; sampled at transfer start
- busy  out  1  transfer in progress
- finished  out  1  transfer completed; held high
- words_written  out  SIZE_WIDTH  words strobed in the current or last transfer
- ready  in  2  ping-pong FIFO channel ready flags
- activate  out  2  channel ownership, one-hot or zero
- fifo_size  in  SIZE_WIDTH  capacity of the channel being granted
- fifo_data  out  DATA_WIDTH  write data
- strobe  out  1  write-data strobe

Behaviour:
- Reset (rst=0 at a clk edge) drives all outputs to 0 and sets the state to IDLE. Reset mid-transfer abandons the transfer immediately: activate drops on the next edge and no further strobes occur.
- States: IDLE, GRAB, WRITE, RELEASE, DONE.
- IDLE:
  - If enable=1 and finished=0: latch write_count into remaining, latch pattern_seed into next_data, clear words_written, set busy=1.
  - If the latched count is 0, go to DONE. Otherwise go to GRAB.
- GRAB:
  - Wait until activate==0 and ready!=0.
  - Grant activate[0] if ready[0]=1, else activate[1]; channel 0 wins when both are ready.
  - On the cycle after the grant, latch chunk = min(fifo_size, remaining) and go to WRITE.
- WRITE:
  - One strobe per cycle, with fifo_data = next_data in the same cycle as strobe=1.
  - Each strobe increments next_data (modulo 2^DATA_WIDTH, so 0xFFFFFFFF wraps to 0x00000000), increments words_written and decrements remaining.
  - After the chunk-th strobe, go to RELEASE.
  - A chunk of 0 (fifo_size=0) produces no strobe and goes straight to RELEASE, so the block cannot deadlock.
  - Strobes are contiguous within a chunk. The first strobe comes at the earliest 2 cycles after activate rises.
- RELEASE:
  - Drive activate to 0 for exactly one cycle.
  - Then: if remaining==0, go to DONE; else if enable=0, abort to IDLE with busy=0 and finished=0; else go to GRAB.
- DONE:
  - busy=0 and finished=1.
  - finished stays high until enable=0, then clears and the state returns to IDLE. A new transfer therefore requires enable to toggle low and then high.
- enable falling during WRITE does not truncate the chunk. The current chunk always completes and the channel is released before the abort.
- Changes to write_count or pattern_seed after start have no effect.
- words_written holds its final value until the next start or reset.
- Invariants:
  - strobe=1 only while exactly one activate bit is 1.
  - activate never changes while strobe=1.
  - The number of strobes per activation never exceeds the fifo_size sampled for that activation.

Test Plan:
- Reset then enable=1, write_count=4, seed=0x00000010, ready=01, fifo_size=512 -> activate=01, 4 strobes with data 0x10,0x11,0x12,0x13, 1-cycle release, then finished=1, words_written=4, busy=0.
- write_count=1000, fifo_size=512, ready toggling between channels -> chunks of 512 then 488 on alternating channels; data is contiguous across the chunk boundary; words_written=1000.
- seed=0xFFFFFFFE, write_count=4 -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- write_count=0 -> no activate and no strobe; finished=1 one cycle after start. Hold enable=1 -> no restart. enable=0 -> finished=0.
- ready=11 at grant -> activate=01 chosen. fifo_size=0 on one grant -> zero strobes, release, retry on next ready; final count is still exact.
- rst=0 asserted mid-chunk after 100 of 512 words -> next cycle all outputs are 0. Deassert enable mid-chunk (no reset) -> the 512-word chunk completes, then busy=0 and finished=0.
